// File: rtl/prog_loader_ctrl_pkg.sv
// Shared state encoding and opcode constants for the program loader and the
// datapath opcode comparators.
package prog_loader_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    DONE,
    ERR
  } state_t;

  localparam logic [4:0] OP_HALT = 5'd31;
  localparam logic [4:0] OP_LW   = 5'd4;
  localparam logic [4:0] OP_SW   = 5'd5;

  function automatic logic state_is_busy(input state_t s);
    return (s == LOAD) || (s == SETTLE) || (s == RUN);
  endfunction

endpackage

// File: rtl/prog_loader_ctrl_cntr.sv
// Free-running up-counter with synchronous clear and count enable.
module prog_loader_ctrl_cntr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/prog_loader_ctrl.sv
// Streams a host program into program memory, holds the core in reset while
// loading, then releases it until a halt opcode or the run-cycle watchdog.
module prog_loader_ctrl
  import prog_loader_ctrl_pkg::*;
#(
  parameter int               WIDTH      = 9,
  parameter int               RAM_WIDTH  = 32,
  parameter logic [4:0]       HALT_OP    = OP_HALT,
  parameter int               CYC_W      = 16,
  parameter logic [CYC_W-1:0] MAX_CYCLES = 16'd1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [RAM_WIDTH-1:0] load_data,
  input  logic                 load_last,
  output logic                 pm_we,
  output logic [WIDTH-1:0]     pm_addr,
  output logic [RAM_WIDTH-1:0] pm_wdata,
  output logic                 core_reset,
  input  logic [4:0]           instr_opcode,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH:0]       word_cnt,
  output logic [CYC_W-1:0]     cyc_cnt
);

  localparam logic [WIDTH-1:0] ADDR_MAX  = '1;
  localparam logic [CYC_W-1:0] WDOG_LAST = MAX_CYCLES - 1'b1;

  state_t         state_reg, state_next;
  logic [WIDTH-1:0] addr_reg, addr_next;
  logic [WIDTH:0]   word_cnt_reg, word_cnt_next;
  logic             cnt_clr;
  logic             cnt_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      word_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      word_cnt_reg <= word_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    word_cnt_next = word_cnt_reg;
    load_ready    = 1'b0;
    pm_we         = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;

    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next    = LOAD;
          addr_next     = '0;
          word_cnt_next = '0;
          cnt_clr       = 1'b1;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          pm_we         = 1'b1;
          word_cnt_next = word_cnt_reg + 1'b1;
          // The top address is written but never wrapped past.
          if (addr_reg != ADDR_MAX) begin
            addr_next = addr_reg + 1'b1;
          end
          if (load_last) begin
            state_next = SETTLE;
          end else if (addr_reg == ADDR_MAX) begin
            state_next = ERR;
          end
        end
      end
      SETTLE: begin
        state_next = RUN;
      end
      RUN: begin
        cnt_en = 1'b1;
        if ((instr_opcode == HALT_OP) || (cyc_cnt == WDOG_LAST)) begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  prog_loader_ctrl_cntr #(
    .W (CYC_W)
  ) run_cntr (
    .clk   (clk),
    .srst  (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cyc_cnt)
  );

  assign pm_addr    = addr_reg;
  assign pm_wdata   = load_data;
  assign word_cnt   = word_cnt_reg;
  assign busy       = state_is_busy(state_reg);
  assign done       = (state_reg == DONE);
  assign err        = (state_reg == ERR);
  assign core_reset = (state_reg != RUN);

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Randomized session-level bench for prog_loader_ctrl: expected writes, counts
// and run lengths come from a transaction model of each load/run session.
module tb_prog_loader_ctrl;

  localparam int               W     = 3;
  localparam int               RW    = 32;
  localparam int               CW    = 16;
  localparam logic [CW-1:0]    MAXC  = 16'd8;
  localparam int               DEPTH = 1 << W;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          load_valid;
  logic          load_ready;
  logic [RW-1:0] load_data;
  logic          load_last;
  logic          pm_we;
  logic [W-1:0]  pm_addr;
  logic [RW-1:0] pm_wdata;
  logic          core_reset;
  logic [4:0]    instr_opcode;
  logic          busy;
  logic          done;
  logic          err;
  logic [W:0]    word_cnt;
  logic [CW-1:0] cyc_cnt;

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] exp_mem [DEPTH];
  logic [RW-1:0] dut_mem [DEPTH];
  int            wr_count = 0;

  prog_loader_ctrl #(
    .WIDTH      (W),
    .RAM_WIDTH  (RW),
    .HALT_OP    (5'd31),
    .CYC_W      (CW),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_last    (load_last),
    .pm_we        (pm_we),
    .pm_addr      (pm_addr),
    .pm_wdata     (pm_wdata),
    .core_reset   (core_reset),
    .instr_opcode (instr_opcode),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .word_cnt     (word_cnt),
    .cyc_cnt      (cyc_cnt)
  );

  always #5 clk = ~clk;

  // Program memory as seen by the bench: captures every DUT write.
  always @(posedge clk) begin
    if (pm_we) begin
      dut_mem[pm_addr] <= pm_wdata;
      wr_count         <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_core_reset"}, core_reset, 1);
    check({tag, "_load_ready"}, load_ready, 0);
    check({tag, "_pm_we"},      pm_we,      0);
    check({tag, "_pm_addr"},    pm_addr,    0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
    check({tag, "_err"},        err,        0);
    check({tag, "_word_cnt"},   word_cnt,   0);
    check({tag, "_cyc_cnt"},    cyc_cnt,    0);
  endtask

  // valid_mode: 0 = valid every cycle, 1 = toggling 1,0,1,..., 2 = random.
  // halt_cyc: RUN cycle (1-based) carrying the halt opcode, 0 = never.
  // abort_cyc: 0-based RUN cycle during which reset+start is asserted, -1 = none.
  task automatic session(input int nwords, input bit overflow, input int halt_cyc,
                         input int abort_cyc, input int valid_mode);
    int            idx;
    int            load_cycles;
    int            run_len;
    int            base_wr;
    bit            v;
    logic [RW-1:0] data;
    logic [W:0]    exp_addr;

    start = 1'b1; load_valid = 1'b0; load_last = 1'b0; instr_opcode = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    base_wr = wr_count;
    idx = 0;
    load_cycles = 0;

    while (idx < nwords) begin
      case (valid_mode)
        0:       v = 1'b1;
        1:       v = (load_cycles % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      data       = $urandom;
      load_valid = v;
      load_data  = data;
      load_last  = !overflow && (idx == nwords - 1);
      @(negedge clk);
      if (overflow && idx == DEPTH) begin
        check("ovf_ready",      load_ready, 0);
        check("ovf_we",         pm_we,      0);
        check("ovf_err",        err,        1);
        check("ovf_busy",       busy,       0);
        check("ovf_core_reset", core_reset, 1);
        check("ovf_word_cnt",   word_cnt,   DEPTH);
        check("ovf_addr",       pm_addr,    DEPTH - 1);
        break;
      end
      check("ld_ready",      load_ready, 1);
      check("ld_busy",       busy,       1);
      check("ld_core_reset", core_reset, 1);
      check("ld_we",         pm_we,      v);
      check("ld_word_cnt",   word_cnt,   idx);
      if (v) begin
        check("ld_addr",  pm_addr,  idx);
        check("ld_wdata", pm_wdata, data);
        exp_mem[idx] = data;
        idx++;
      end
      load_cycles++;
      @(posedge clk); #1;
      if (load_cycles > 1000) begin
        check("load_timeout", 0, 1);
        break;
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;

    if (!overflow) begin
      @(negedge clk);
      exp_addr = (nwords < DEPTH) ? (W+1)'(nwords) : (W+1)'(DEPTH - 1);
      check("settle_core_reset", core_reset, 1);
      check("settle_busy",       busy,       1);
      check("settle_we",         pm_we,      0);
      check("settle_ready",      load_ready, 0);
      check("settle_word_cnt",   word_cnt,   nwords);
      check("settle_addr",       pm_addr,    exp_addr[W-1:0]);
      @(posedge clk); #1;

      run_len = (halt_cyc > 0 && halt_cyc <= int'(MAXC)) ? halt_cyc : int'(MAXC);
      for (int k = 0; k < run_len; k++) begin
        instr_opcode = (k == halt_cyc - 1) ? 5'd31 : 5'($urandom_range(0, 30));
        if (k == abort_cyc) begin
          reset = 1'b1;
          start = 1'b1;
        end
        @(negedge clk);
        check("run_core_reset", core_reset, 0);
        check("run_busy",       busy,       1);
        check("run_done",       done,       0);
        check("run_cyc_cnt",    cyc_cnt,    k);
        @(posedge clk); #1;
        if (k == abort_cyc) begin
          reset = 1'b0;
          start = 1'b0;
          instr_opcode = 5'd0;
          @(negedge clk);
          check_idle("abort");
          $display("session n=%0d mode=%0d aborted in run cycle %0d", nwords, valid_mode, k + 1);
          return;
        end
      end
      instr_opcode = 5'd0;
      @(negedge clk);
      check("fin_done",       done,       1);
      check("fin_core_reset", core_reset, 1);
      check("fin_busy",       busy,       0);
      check("fin_err",        err,        0);
      check("fin_cyc_cnt",    cyc_cnt,    run_len);
      check("fin_word_cnt",   word_cnt,   nwords);
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_done",    done,    1);
      check("hold_cyc_cnt", cyc_cnt, run_len);
    end

    check("wr_count", wr_count - base_wr, idx);
    for (int a = 0; a < idx; a++) begin
      check("mem", dut_mem[a], exp_mem[a]);
    end
    $display("session n=%0d ovf=%0d halt=%0d mode=%0d: %0d words written",
             nwords, overflow, halt_cyc, valid_mode, idx);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b1; load_valid = 1'b1; load_data = '0;
    load_last = 1'b0; instr_opcode = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    check_idle("idle");
    @(posedge clk); #1;

    session(3, 1'b0, 4, -1, 0);              // three words back to back, halt on 4th run cycle
    session(3, 1'b0, 0, -1, 1);              // gapped valid, watchdog ends the run
    session(DEPTH + 1, 1'b1, 0, -1, 0);      // overflow without load_last
    session(5, 1'b0, 6, 1, 0);               // reset+start in the second run cycle
    session(2, 1'b0, 2, -1, 0);              // restart from address 0 after abort
    session(DEPTH, 1'b0, int'(MAXC), -1, 2); // last word lands on the top address
    repeat (20) begin
      session($urandom_range(1, DEPTH), 1'b0, $urandom_range(0, 10), -1, 2);
    end
    session(DEPTH + 1, 1'b1, 0, -1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
